sm2_kdf_ctrl: RTL

- SM2 key-derivation controller placed directly upstream of the 1024-bit-message SM3 hash core (sm3_1024_top).
- Latches x2||y2 (512 bit) and klen, then issues one hash request per 256-bit block with counter ct = 1, 2, ...
- Concatenates the returned digests into a left-aligned key buffer, truncates to klen bits, and flags an all-zero result (SM2 reject condition).

---
 rtl/sm2_kdf_pkg.sv | 28 ++
 rtl/sm2_kdf_keybuf.sv | 83 ++++++++
 rtl/sm2_kdf_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sm2_kdf_pkg.sv
// Shared types and constants for the SM2 key-derivation controller.
// Optional zero-key detection is enabled by defining SM2_KDF_ZERO_CHECK_EN.
package sm2_kdf_pkg;

    localparam int unsigned SM3_DIGEST_W = 256;
    localparam int unsigned SM3_DATA_W   = 512;
    localparam int unsigned CT_W         = 32;

    localparam logic [CT_W-1:0] KDF_CT_INIT = 32'h00000001;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_DONE  = 4'b1000
    } kdf_state_e;

    // Request payload presented to the hash core for the duration of a block.
    typedef struct packed {
        logic [SM3_DATA_W-1:0] data;
        logic [CT_W-1:0]       append;
    } sm3_req_t;

    function automatic int unsigned slot_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sm2_kdf_keybuf.sv
// Left-aligned key buffer: slot writes, klen truncation and optional zero flag.
// Zero reduction is built only when SM2_KDF_ZERO_CHECK_EN is defined.
module sm2_kdf_keybuf
    import sm2_kdf_pkg::*;
#(
    parameter int unsigned MAX_BLOCKS = 4,
    parameter int unsigned KLEN_W     = 11,
    parameter int unsigned SLOT_W     = slot_w(MAX_BLOCKS)
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               clr,
    input  logic                               wr_en,
    input  logic [SLOT_W-1:0]                  wr_slot,
    input  logic [SM3_DIGEST_W-1:0]            wr_data,
    input  logic                               fin,
    input  logic [KLEN_W-1:0]                  klen,
    output logic [SM3_DIGEST_W*MAX_BLOCKS-1:0] key_out,
    output logic                               kdf_zero
);

    localparam int unsigned KEY_W = SM3_DIGEST_W * MAX_BLOCKS;
    localparam logic [KEY_W-1:0] ONES = '1;

    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_d;
    logic [KEY_W-1:0] trunc_mask;

    // Ones in the leftmost klen positions; klen >= KEY_W keeps everything.
    assign trunc_mask = ~(ONES >> klen);

    always_comb begin
        key_d = key_q;
        if (clr) begin
            key_d = '0;
        end else if (wr_en) begin
            for (int unsigned s = 0; s < MAX_BLOCKS; s++) begin
                if (wr_slot == SLOT_W'(s)) begin
                    key_d[KEY_W-1-s*SM3_DIGEST_W -: SM3_DIGEST_W] = wr_data;
                end
            end
        end else if (fin) begin
            key_d = key_q & trunc_mask;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_q <= '0;
        end else begin
            key_q <= key_d;
        end
    end

    assign key_out = key_q;

`ifdef SM2_KDF_ZERO_CHECK_EN
    logic zero_q;
    logic zero_d;

    always_comb begin
        zero_d = zero_q;
        if (clr) begin
            zero_d = 1'b0;
        end else if (fin) begin
            zero_d = ~|(key_q & trunc_mask);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign kdf_zero = zero_q;
`else
    assign kdf_zero = 1'b0;
`endif

endmodule

// File: rtl/sm2_kdf_ctrl.sv
// SM2 KDF controller: one SM3 request per 256-bit block, ct = 1, 2, ...
// kdf_zero is live only when SM2_KDF_ZERO_CHECK_EN is defined.
module sm2_kdf_ctrl
    import sm2_kdf_pkg::*;
#(
    parameter int unsigned MAX_BLOCKS = 4,
    parameter int unsigned KLEN_W     = 11
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               start,
    input  logic [SM3_DATA_W-1:0]              xy_in,
    input  logic [KLEN_W-1:0]                  klen,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic                               kdf_zero,
    output logic [SM3_DIGEST_W*MAX_BLOCKS-1:0] key_out,
    output logic [SM3_DATA_W-1:0]              sm3_data,
    output logic [CT_W-1:0]                    sm3_append,
    output logic                               sm3_start,
    input  logic [SM3_DIGEST_W-1:0]            sm3_hash,
    input  logic                               sm3_valid
);

    localparam int unsigned KEY_W  = SM3_DIGEST_W * MAX_BLOCKS;
    localparam int unsigned SLOT_W = slot_w(MAX_BLOCKS);
    localparam int unsigned NBLK_W = KLEN_W - 7;
    localparam int unsigned SUM_W  = KLEN_W + 1;

    kdf_state_e        state_q, state_d;
    sm3_req_t          req_q, req_d;
    logic [CT_W-1:0]   ct_q, ct_d;
    logic [NBLK_W-1:0] blk_q, blk_d;
    logic [NBLK_W-1:0] nblk_q, nblk_d;
    logic [KLEN_W-1:0] klen_q, klen_d;
    logic              sm3_start_q, sm3_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              kb_clr;
    logic              kb_wr;
    logic              kb_fin;
    logic [NBLK_W-1:0] nblk_in;

    function automatic logic klen_bad(input logic [KLEN_W-1:0] k);
        return (k == '0) || (32'(k) > KEY_W);
    endfunction

    assign nblk_in = NBLK_W'((SUM_W'(klen) + SUM_W'(255)) >> 8);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        ct_d        = ct_q;
        blk_d       = blk_q;
        nblk_d      = nblk_q;
        klen_d      = klen_q;
        sm3_start_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        kb_clr      = 1'b0;
        kb_wr       = 1'b0;
        kb_fin      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    req_d.data = xy_in;
                    klen_d     = klen;
                    nblk_d     = nblk_in;
                    ct_d       = KDF_CT_INIT;
                    blk_d      = '0;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    kb_clr     = 1'b1;
                    if (klen_bad(klen)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d      = ST_ISSUE;
                        sm3_start_d  = 1'b1;
                        req_d.append = KDF_CT_INIT;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sm3_valid) begin
                    kb_wr = 1'b1;
                    if (blk_q == nblk_q - NBLK_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        blk_d        = blk_q + NBLK_W'(1);
                        ct_d         = ct_q + CT_W'(1);
                        req_d.append = ct_q + CT_W'(1);
                        sm3_start_d  = 1'b1;
                        state_d      = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                kb_fin  = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = klen_bad(klen_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            ct_q        <= KDF_CT_INIT;
            blk_q       <= '0;
            nblk_q      <= '0;
            klen_q      <= '0;
            sm3_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            ct_q        <= ct_d;
            blk_q       <= blk_d;
            nblk_q      <= nblk_d;
            klen_q      <= klen_d;
            sm3_start_q <= sm3_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    sm2_kdf_keybuf #(
        .MAX_BLOCKS (MAX_BLOCKS),
        .KLEN_W     (KLEN_W),
        .SLOT_W     (SLOT_W)
    ) u_keybuf (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (kb_clr),
        .wr_en    (kb_wr),
        .wr_slot  (SLOT_W'(blk_q)),
        .wr_data  (sm3_hash),
        .fin      (kb_fin),
        .klen     (klen_q),
        .key_out  (key_out),
        .kdf_zero (kdf_zero)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign sm3_data   = req_q.data;
    assign sm3_append = req_q.append;
    assign sm3_start  = sm3_start_q;

endmodule
